// File: rtl/ff_pipe_pkg.sv
// ff_pipe_pkg: sizing helpers shared by the ff_pipe register pipeline.
package ff_pipe_pkg;
   function automatic int rec_w(input int width);
      return width + 1;
   endfunction
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/ff_pipe_if.sv
// ff_pipe_if: data/control inputs and status outputs of the ff_pipe pipeline.
interface ff_pipe_if
   import ff_pipe_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   logic [WIDTH-1:0]          d;
   logic                      dv;
   logic                      e;
   logic                      clr;
   logic [WIDTH-1:0]          q;
   logic                      qv;
   logic [cnt_w(DEPTH)-1:0]   cnt;
   logic                      full;
   modport master (output d, dv, e, clr, input q, qv, cnt, full);
   modport slave  (input d, dv, e, clr, output q, qv, cnt, full);
endinterface

// File: rtl/ff_stage.sv
// ff_stage: one {data, valid} pipeline stage with load, sync clear and async active-low reset.
module ff_stage
   import ff_pipe_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                    clk,
   input  logic                    r,
   input  logic                    ld,
   input  logic                    clr,
   input  logic [rec_w(WIDTH)-1:0] din,
   output logic [rec_w(WIDTH)-1:0] dout
);
   always_ff @(posedge clk or negedge r)
      if (!r) dout <= {RESET_VAL, 1'b0};
      else if (clr) dout <= {RESET_VAL, 1'b0};
      else if (ld) dout <= din;
endmodule

// File: rtl/ff_pipe.sv
// ff_pipe: WIDTH x DEPTH register pipeline with per-stage valid, global enable,
// sync clear, optional bubble collapse while stalled and a registered occupancy count.
module ff_pipe
   import ff_pipe_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter int               DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter bit               COLLAPSE  = 1'b0
) (
   input  logic      clk,
   input  logic      r,
   ff_pipe_if.slave  p
);
   localparam int SW = rec_w(WIDTH);
   localparam int CW = cnt_w(DEPTH);
   logic [SW-1:0]    stg [DEPTH];
   logic [DEPTH-1:0] vld;
   logic [DEPTH-1:0] bub_ge;
   logic [DEPTH-1:0] ld;
   logic [CW-1:0]    cnt;
   // bub_ge[i]: some stage at index >= i is empty, so stage i may move up while stalled
   always_comb begin
      vld    = '0;
      bub_ge = '0;
      for (int i = 0; i < DEPTH; i++) vld[i] = stg[i][0];
      for (int i = 0; i < DEPTH; i++) bub_ge[i] = |((~vld) >> i);
      ld = {DEPTH{p.e}} | ({DEPTH{COLLAPSE}} & bub_ge);
   end
   for (genvar g = 0; g < DEPTH; g++) begin : s
      logic [SW-1:0] din;
      if (g == 0) begin : h
         assign din = {p.d, p.dv};
      end else begin : t
         assign din = stg[g-1];
      end
      ff_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
         .clk  (clk),
         .r    (r),
         .ld   (ld[g]),
         .clr  (p.clr),
         .din  (din),
         .dout (stg[g])
      );
   end
   always_ff @(posedge clk or negedge r)
      if (!r) cnt <= '0;
      else if (p.clr) cnt <= '0;
      else if (p.e) cnt <= cnt + CW'(p.dv) - CW'(vld[DEPTH-1]);
      else if (COLLAPSE && bub_ge[0]) cnt <= cnt + CW'(p.dv);
   assign p.q    = stg[DEPTH-1][SW-1:1];
   assign p.qv   = vld[DEPTH-1];
   assign p.cnt  = cnt;
   assign p.full = cnt == CW'(DEPTH);
endmodule

// File: tb/tb_ff_pipe.sv
// tb_ff_pipe: scoreboard bench driving a holding and a collapsing ff_pipe against a queue model.
module tb_ff_pipe;
   localparam int         WIDTH = 8;
   localparam int         DEPTH = 4;
   localparam logic [7:0] RV    = 8'h5A;
   typedef logic [WIDTH:0] rec_t;
   typedef rec_t recq_t[$];
   typedef struct packed {
      logic [12:0] a;
      logic [12:0] b;
   } exp_t;
   logic  clk;
   logic  r;
   int    total;
   int    bad;
   recq_t m0;
   recq_t m1;
   exp_t  sb[$];
   ff_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) pif0 ();
   ff_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) pif1 ();
   ff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV), .COLLAPSE(1'b0)) dut0 (
      .clk (clk),
      .r   (r),
      .p   (pif0)
   );
   ff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV), .COLLAPSE(1'b1)) dut1 (
      .clk (clk),
      .r   (r),
      .p   (pif1)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   // model: index 0 is the input stage, index DEPTH-1 the output stage
   function automatic recq_t rst_state();
      recq_t n;
      repeat (DEPTH) n.push_back({RV, 1'b0});
      return n;
   endfunction
   function automatic recq_t next_state(recq_t s, bit col, logic [7:0] d, logic dv, logic e, logic clr);
      recq_t n = s;
      if (clr) return rst_state();
      if (e) begin
         n.push_front({d, dv});
         void'(n.pop_back());
         return n;
      end
      if (col)
         for (int k = DEPTH - 1; k >= 0; k--)
            if (!n[k][0]) begin
               n.delete(k);
               n.push_front({d, dv});
               break;
            end
      return n;
   endfunction
   function automatic logic [12:0] outs(recq_t s);
      int n = 0;
      foreach (s[i]) n += int'(s[i][0]);
      return {s[DEPTH-1][WIDTH:1], s[DEPTH-1][0], 3'(n), n == DEPTH};
   endfunction
   task automatic chk(input string name, input logic [12:0] act, input logic [12:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s at %0t: got=%h want=%h", name, $time, act, want);
      end
   endtask
   always @(negedge clk)
      if (sb.size() > 0) begin
         exp_t x;
         x = sb.pop_front();
         chk("pipe0 {q,qv,cnt,full}", {pif0.q, pif0.qv, pif0.cnt, pif0.full}, x.a);
         chk("pipe1 {q,qv,cnt,full}", {pif1.q, pif1.qv, pif1.cnt, pif1.full}, x.b);
         chk("pipe0 cnt vs popcount", 13'(pif0.cnt), 13'($countones(dut0.vld)));
         chk("pipe1 cnt vs popcount", 13'(pif1.cnt), 13'($countones(dut1.vld)));
      end
   // every task starts and ends at a falling clock edge
   task automatic step(input logic [7:0] d, input logic dv, input logic e, input logic clr);
      {pif0.d, pif0.dv, pif0.e, pif0.clr} = {d, dv, e, clr};
      {pif1.d, pif1.dv, pif1.e, pif1.clr} = {d, dv, e, clr};
      m0 = next_state(m0, 1'b0, d, dv, e, clr);
      m1 = next_state(m1, 1'b1, d, dv, e, clr);
      @(posedge clk);
      sb.push_back('{a: outs(m0), b: outs(m1)});
      @(negedge clk);
   endtask
   task automatic rst_pulse();
      #2 r = 1'b0;
      #1;
      chk("async reset pipe0", {pif0.q, pif0.qv, pif0.cnt, pif0.full}, {RV, 1'b0, 3'd0, 1'b0});
      chk("async reset pipe1", {pif1.q, pif1.qv, pif1.cnt, pif1.full}, {RV, 1'b0, 3'd0, 1'b0});
      m0 = rst_state();
      m1 = rst_state();
      @(posedge clk);
      sb.push_back('{a: outs(m0), b: outs(m1)});
      @(negedge clk);
      r = 1'b1;
   endtask
   initial begin
      total = 0;
      bad   = 0;
      r     = 1'b1;
      {pif0.d, pif0.dv, pif0.e, pif0.clr} = '0;
      {pif1.d, pif1.dv, pif1.e, pif1.clr} = '0;
      @(negedge clk);
      rst_pulse();
      for (int i = 1; i <= 4; i++) step(8'(i * 8'h11), 1'b1, 1'b1, 1'b0);
      rst_pulse();
      step(8'h77, 1'b1, 1'b1, 1'b0);
      repeat (4) step(8'($urandom), 1'b0, 1'b1, 1'b0);
      step(8'hA5, 1'b1, 1'b1, 1'b0);
      repeat (5) step(8'($urandom), 1'b0, 1'b1, 1'b0);
      step(8'h00, 1'b0, 1'b0, 1'b1);
      step(8'hA1, 1'b1, 1'b1, 1'b0);
      step(8'h0F, 1'b0, 1'b1, 1'b0);
      step(8'hB2, 1'b1, 1'b1, 1'b0);
      step(8'hF0, 1'b0, 1'b1, 1'b0);
      for (int i = 1; i <= 3; i++) step(8'(i), 1'b1, 1'b0, 1'b0);
      repeat (4) step(8'hEE, 1'b0, 1'b1, 1'b0);
      step(8'hC3, 1'b1, 1'b1, 1'b1);
      step(8'hD4, 1'b1, 1'b1, 1'b0);
      step(8'hD5, 1'b1, 1'b1, 1'b1);
      step(8'hD6, 1'b1, 1'b0, 1'b0);
      repeat (1000)
         if ($urandom_range(63) == 0) rst_pulse();
         else step(8'($urandom), 1'($urandom_range(1)), $urandom_range(3) != 0, $urandom_range(15) == 0);
      repeat (2) @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
